arb_req_agent: RTL and testbench

ARB_REQ_AGENT -- requirements
Module: arb_req_agent

---
 rtl/arb_req_agent.sv | 128 ++++++++++++
 tb/tb_arb_req_agent.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_agent.sv
// arb_req_agent: per-channel pending counters feeding a priority arbiter.
// Optional starvation detection is enabled by defining ARB_REQ_TIMEOUT_EN.
module arb_req_agent #(
   parameter int CNT_W = 3,
   parameter int COOL  = 2,
   parameter int TMO   = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] push,
   output logic [3:0] full,
   output logic [3:0] req,
   input  logic [3:0] grant,
   input  logic       vld,
   output logic [3:0] issue,
   output logic [3:0] ovf,
   output logic       err,
   output logic [3:0] starve
);

   localparam int CW = (COOL > 0) ? $clog2(COOL + 1) : 1;
   localparam logic [CNT_W-1:0] PMAX = '1;
   localparam logic [CW-1:0] COOL_V = CW'(COOL);

   logic [3:0][CNT_W-1:0] pend_q, pend_d;
   logic [3:0][CW-1:0]    cool_q, cool_d;
   logic [3:0]            issue_q, issue_d;
   logic [3:0]            ovf_q, ovf_d;
   logic                  err_q, err_d;
   logic                  one_hot;
   logic                  legal;
   logic [3:0]            gnt_v;

   // request and full flags derived from registered state only
   always_comb begin
      req  = '0;
      full = '0;
      for (int i = 0; i < 4; i++) begin
         req[i]  = (pend_q[i] != '0) && (cool_q[i] == '0);
         full[i] = (pend_q[i] == PMAX);
      end
   end

   // qualify the arbiter grant: one-hot and aimed at a requesting channel
   always_comb begin
      one_hot = (grant != 4'd0) && ((grant & (grant - 4'd1)) == 4'd0);
      legal   = vld && one_hot && ((grant & req) != 4'd0);
      gnt_v   = legal ? grant : 4'd0;
   end

   // next-state for counters, cooldowns and sticky flags
   always_comb begin
      pend_d  = pend_q;
      cool_d  = cool_q;
      ovf_d   = ovf_q;
      err_d   = err_q | (vld & ~legal);
      issue_d = gnt_v;
      for (int i = 0; i < 4; i++) begin
         if (gnt_v[i] && !push[i]) begin
            if (pend_q[i] != '0) pend_d[i] = pend_q[i] - 1'b1;
         end else if (push[i] && !gnt_v[i]) begin
            if (pend_q[i] == PMAX) ovf_d[i] = 1'b1;
            else pend_d[i] = pend_q[i] + 1'b1;
         end
         if (gnt_v[i]) cool_d[i] = COOL_V;
         else if (cool_q[i] != '0) cool_d[i] = cool_q[i] - 1'b1;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_q  <= '0;
         cool_q  <= '0;
         issue_q <= '0;
         ovf_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         cool_q  <= cool_d;
         issue_q <= issue_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign issue = issue_q;
   assign ovf   = ovf_q;
   assign err   = err_q;

`ifdef ARB_REQ_TIMEOUT_EN
   localparam int WW = (TMO > 1) ? $clog2(TMO + 1) : 1;
   localparam logic [WW-1:0] TMO_V = WW'(TMO);

   logic [3:0][WW-1:0] wait_q, wait_d;
   logic [3:0]         starve_q, starve_d;

   // count cycles spent requesting without being served
   always_comb begin
      wait_d   = wait_q;
      starve_d = starve_q;
      for (int i = 0; i < 4; i++) begin
         if (req[i] && !gnt_v[i]) begin
            if (wait_q[i] != TMO_V) wait_d[i] = wait_q[i] + 1'b1;
         end else begin
            wait_d[i] = '0;
         end
         if (wait_d[i] == TMO_V) starve_d[i] = 1'b1;
      end
   end

   // wait counters and sticky starvation flags
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wait_q   <= '0;
         starve_q <= '0;
      end else begin
         wait_q   <= wait_d;
         starve_q <= starve_d;
      end
   end

   assign starve = starve_q;
`else
   assign starve = 4'b0000;
`endif

endmodule

// File: tb/tb_arb_req_agent.sv
// tb_arb_req_agent: directed and random stimulus against a
// behavioural model of the request agent.
module tb_arb_req_agent;

   localparam int CNT_W = 3;
   localparam int COOL  = 2;
   localparam int TMO   = 16;
   localparam int PMAX  = (1 << CNT_W) - 1;

   logic       clk;
   logic       resetn;
   logic [3:0] push;
   logic [3:0] full;
   logic [3:0] req;
   logic [3:0] grant;
   logic       vld;
   logic [3:0] issue;
   logic [3:0] ovf;
   logic       err;
   logic [3:0] starve;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int         m_pend [4];
   int         m_cool [4];
   int         m_wait [4];
   logic [3:0] m_issue;
   logic [3:0] m_ovf;
   logic       m_err;
   logic [3:0] m_starve;

   arb_req_agent #(
      .CNT_W(CNT_W),
      .COOL (COOL),
      .TMO  (TMO)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .push  (push),
      .full  (full),
      .req   (req),
      .grant (grant),
      .vld   (vld),
      .issue (issue),
      .ovf   (ovf),
      .err   (err),
      .starve(starve)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] m_req();
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         r[i] = (m_pend[i] != 0) && (m_cool[i] == 0);
      return r;
   endfunction

   function automatic logic [3:0] m_full();
      logic [3:0] f;
      f = '0;
      for (int i = 0; i < 4; i++) f[i] = (m_pend[i] == PMAX);
      return f;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 4; i++) begin
         m_pend[i] = 0;
         m_cool[i] = 0;
         m_wait[i] = 0;
      end
      m_issue  = '0;
      m_ovf    = '0;
      m_err    = 1'b0;
      m_starve = '0;
   endtask

   task automatic m_step(input logic [3:0] p, input logic [3:0] g, input logic v);
      logic [3:0] r;
      bit         ok;
      bit         gi;
      r  = m_req();
      ok = v && ($countones(g) == 1) && ((g & r) != 0);
      for (int i = 0; i < 4; i++) begin
         gi = ok && g[i];
         if (gi && !p[i]) m_pend[i] = m_pend[i] - 1;
         else if (p[i] && !gi) begin
            if (m_pend[i] == PMAX) m_ovf[i] = 1'b1;
            else m_pend[i] = m_pend[i] + 1;
         end
         if (gi) m_cool[i] = COOL;
         else if (m_cool[i] > 0) m_cool[i] = m_cool[i] - 1;
`ifdef ARB_REQ_TIMEOUT_EN
         if (r[i] && !gi) begin
            if (m_wait[i] < TMO) m_wait[i] = m_wait[i] + 1;
            if (m_wait[i] >= TMO) m_starve[i] = 1'b1;
         end else m_wait[i] = 0;
`endif
      end
      if (v && !ok) m_err = 1'b1;
      m_issue = ok ? g : 4'b0;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".req"}, req, m_req());
      chk({tag, ".full"}, full, m_full());
      chk({tag, ".issue"}, issue, m_issue);
      chk({tag, ".ovf"}, ovf, m_ovf);
      chk({tag, ".err"}, {3'b0, err}, {3'b0, m_err});
      chk({tag, ".starve"}, starve, m_starve);
   endtask

   task automatic cyc(input string tag, input logic [3:0] p,
                      input logic [3:0] g, input logic v);
      push  = p;
      grant = g;
      vld   = v;
      m_step(p, g, v);
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   task automatic mid_reset(input string tag);
      push   = '0;
      grant  = '0;
      vld    = 1'b0;
      resetn = 1'b0;
      m_reset();
      #1;
      chk_all({tag, ".async"});
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   function automatic logic [3:0] pick_legal(input logic [3:0] r);
      int idx [$];
      for (int i = 0; i < 4; i++) if (r[i]) idx.push_back(i);
      if (idx.size() == 0) return 4'b0;
      return 4'b1 << idx[$urandom_range(0, idx.size() - 1)];
   endfunction

   initial begin
      logic [3:0] p;
      logic [3:0] g;
      logic       v;
      push   = '0;
      grant  = '0;
      vld    = 1'b0;
      resetn = 1'b0;
      m_reset();
      #2;
      chk_all("reset");
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // single request round trip
      cyc("r31.push", 4'b0010, 4'b0, 1'b0);
      chk("r31.req1", req, 4'b0010);
      cyc("r31.gnt", 4'b0, 4'b0010, 1'b1);
      chk("r31.issue", issue, 4'b0010);
      cyc("r31.c1", 4'b0, 4'b0, 1'b0);
      chk("r31.issue_off", issue, 4'b0000);
      cyc("r31.c2", 4'b0, 4'b0, 1'b0);
      cyc("r31.c3", 4'b0, 4'b0, 1'b0);
      chk("r31.req0", req, 4'b0000);

      // fill ch0 to saturation, overflow, then drain
      for (int i = 0; i < 7; i++) cyc("r32.fill", 4'b0001, 4'b0, 1'b0);
      chk("r32.full", full, 4'b0001);
      cyc("r32.ovf", 4'b0001, 4'b0, 1'b0);
      chk("r32.ovf_set", ovf, 4'b0001);
      for (int i = 0; i < 7; i++) begin
         cyc("r32.drain", 4'b0, 4'b0001, 1'b1);
         cyc("r32.cd1", 4'b0, 4'b0, 1'b0);
         cyc("r32.cd2", 4'b0, 4'b0, 1'b0);
      end
      chk("r32.empty", req, 4'b0000);

      // cooldown window on ch3
      cyc("r33.p1", 4'b1000, 4'b0, 1'b0);
      cyc("r33.p2", 4'b1000, 4'b0, 1'b0);
      cyc("r33.gnt", 4'b0, 4'b1000, 1'b1);
      chk("r33.low1", req, 4'b0000);
      cyc("r33.w1", 4'b0, 4'b0, 1'b0);
      chk("r33.low2", req, 4'b0000);
      cyc("r33.w2", 4'b0, 4'b0, 1'b0);
      chk("r33.high", req, 4'b1000);
      cyc("r33.gnt2", 4'b0, 4'b1000, 1'b1);

      // illegal grants: multi-hot, then grant to idle channel
      mid_reset("r34.rst");
      cyc("r34.p", 4'b0010, 4'b0, 1'b0);
      cyc("r34.multi", 4'b0, 4'b0110, 1'b1);
      chk("r34.err1", {3'b0, err}, 4'b0001);
      cyc("r34.idle", 4'b0, 4'b0001, 1'b1);
      chk("r34.noissue", issue, 4'b0000);
      cyc("r34.zero", 4'b0, 4'b0000, 1'b1);
      cyc("r34.novld", 4'b0, 4'b0010, 1'b0);

      // simultaneous push and grant, then asynchronous reset
      mid_reset("r35.rst");
      for (int i = 0; i < 3; i++) cyc("r35.fill", 4'b0010, 4'b0, 1'b0);
      cyc("r35.both", 4'b0010, 4'b0010, 1'b1);
      chk("r35.issue", issue, 4'b0010);
      for (int i = 0; i < 4; i++) cyc("r35.fill7", 4'b0010, 4'b0, 1'b0);
      cyc("r35.cd", 4'b0, 4'b0, 1'b0);
      cyc("r35.bothfull", 4'b0010, 4'b0010, 1'b1);
      chk("r35.noovf", ovf, 4'b0000);
      mid_reset("r35.mid");
      cyc("r35.after", 4'b0, 4'b0, 1'b0);

      // idle requester for starvation window
      cyc("r36.p", 4'b0100, 4'b0, 1'b0);
      for (int i = 0; i < 20; i++) cyc("r36.wait", 4'b0, 4'b0, 1'b0);

      // randomized traffic with periodic resets
      mid_reset("rnd.rst");
      for (int n = 0; n < 1200; n++) begin
         if (n % 150 == 149) mid_reset("rnd.rst");
         p = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         if ($urandom_range(0, 9) < 8) begin
            g = pick_legal(m_req());
            v = (g != 0) && ($urandom_range(0, 3) != 0);
         end else begin
            g = 4'($urandom_range(0, 15));
            v = $urandom_range(0, 1) == 1;
         end
         cyc("rnd", p, g, v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
